// File: rtl/prog_loader.sv
// Byte-stream program loader: header N, then N big-endian 16-bit words into instruction memory, then start/run/done handshake.
// Optional trailer checksum (running XOR of payload bytes) enabled by defining PROG_LOADER_CHKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] im_w_addr,
  output logic [DATA_WIDTH-1:0] im_w_data,
  output logic                  im_wr,
  output logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_CHK,
    S_STRT,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic [7:0]            wcnt_inc;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  start_q, start_d;
`ifdef PROG_LOADER_CHKSUM_EN
  logic                  err_q, err_d;
  logic [7:0]            sum_q, sum_d;
`endif

  assign wcnt_inc = wcnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      err_q   <= 1'b0;
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      start_q <= start_d;
`ifdef PROG_LOADER_CHKSUM_EN
      err_q   <= err_d;
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    // start is registered, so it appears in the first RUN cycle, two cycles after the header/trailer byte
    start_d    = (state_q == S_STRT);
    byte_ready = 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
    err_d      = err_q;
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          n_d    = byte_data;
          wcnt_d = '0;
          idx_d  = '0;
          addr_d = '0;
`ifdef PROG_LOADER_CHKSUM_EN
          err_d  = 1'b0;
          sum_d  = '0;
`endif
          state_d = (byte_data != 8'd0) ? S_HI : S_STRT;
        end
      end
      S_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          hi_d    = byte_data;
`ifdef PROG_LOADER_CHKSUM_EN
          sum_d   = sum_q ^ byte_data;
`endif
          state_d = S_LO;
        end
      end
      S_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          wr_d   = 1'b1;
          data_d = DATA_WIDTH'({hi_q, byte_data});
          addr_d = idx_q;
          idx_d  = idx_q + 1'b1;
          wcnt_d = wcnt_inc;
`ifdef PROG_LOADER_CHKSUM_EN
          sum_d  = sum_q ^ byte_data;
          state_d = (wcnt_inc == n_q) ? S_CHK : S_HI;
`else
          state_d = (wcnt_inc == n_q) ? S_STRT : S_HI;
`endif
        end
      end
      S_CHK: begin
`ifdef PROG_LOADER_CHKSUM_EN
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (byte_data == sum_q) begin
            state_d = S_STRT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_STRT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign im_w_addr = addr_q;
  assign im_w_data = data_q;
  assign im_wr     = wr_q;
  assign start     = start_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
`ifdef PROG_LOADER_CHKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

  a_start_in_run: assert property (@(posedge clk) disable iff (!rst) start |-> (state_q == S_RUN));
  a_wr_one_cycle: assert property (@(posedge clk) disable iff (!rst) im_wr |=> !im_wr);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes/starts, a negedge monitor pops and compares.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [7:0]  im_w_addr;
  logic [15:0] im_w_data;
  logic        im_wr;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_wr[$];
  bit  exp_start[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  prog_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_w_addr  (im_w_addr),
    .im_w_data  (im_w_data),
    .im_wr      (im_wr),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (im_wr === 1'b1) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_im_wr", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("im_w_addr", {24'd0, im_w_addr}, {24'd0, e.a});
          chk("im_w_data", {16'd0, im_w_data}, {16'd0, e.d});
        end
      end
      if (start === 1'b1) begin
        if (exp_start.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          void'(exp_start.pop_front());
          chk("start_expected", {31'd0, start}, 32'd1);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int k;
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    while (byte_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic trailer(input logic [7:0] t, input int gap);
`ifdef PROG_LOADER_CHKSUM_EN
    send(t, gap);
`else
    if (t == 8'hxx) send(t, gap);
`endif
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    chk({name, "_wr_q_empty"}, exp_wr.size(), 0);
    chk({name, "_start_q_empty"}, exp_start.size(), 0);
  endtask

  task automatic do_stop(input string name);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_ready_in_done"}, {31'd0, byte_ready}, 32'd1);
    chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    stop       = 1'b0;
    #1;
    chk("rst_addr", {24'd0, im_w_addr}, 32'd0);
    chk("rst_data", {16'd0, im_w_data}, 32'd0);
    chk("rst_outs", {27'd0, im_wr, start, busy, done, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("ready_after_rst", {31'd0, byte_ready}, 32'd1);

    // Two words back to back
    exp_wr.push_back('{a: 8'd0, d: 16'h1234});
    exp_wr.push_back('{a: 8'd1, d: 16'hABCD});
    exp_start.push_back(1'b1);
    send(8'h02, 0);
    chk("busy_loading", {31'd0, busy}, 32'd1);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'hAB, 0);
    send(8'hCD, 0);
    trailer(8'h40, 0);
    chk("strt_not_ready", {31'd0, byte_ready}, 32'd0);
    chk("strt_no_start_yet", {31'd0, start}, 32'd0);
    @(negedge clk);
    chk("start_pulse", {31'd0, start}, 32'd1);
    @(negedge clk);
    chk("start_one_cycle", {31'd0, start}, 32'd0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    drain("two_words");
    do_stop("two_words");

    // Empty program: start two cycles after header acceptance
    exp_start.push_back(1'b1);
    send(8'h00, 0);
    chk("hdr0_done_cleared", {31'd0, done}, 32'd0);
    chk("hdr0_cycle1_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    chk("hdr0_cycle2_start", {31'd0, start}, 32'd1);
    drain("hdr0");
    do_stop("hdr0");

    // Same stream with 3-cycle host gaps
    exp_wr.push_back('{a: 8'd0, d: 16'h1234});
    exp_wr.push_back('{a: 8'd1, d: 16'hABCD});
    exp_start.push_back(1'b1);
    send(8'h02, 3);
    chk("gap_busy_hi", {30'd0, busy, byte_ready}, 32'd3);
    send(8'h12, 3);
    send(8'h34, 3);
    send(8'hAB, 3);
    send(8'hCD, 3);
    trailer(8'h40, 0);
    drain("gaps");
    do_stop("gaps");

    // stop held throughout the load and STRT
    stop = 1'b1;
    exp_wr.push_back('{a: 8'd0, d: 16'hAA55});
    exp_start.push_back(1'b1);
    send(8'h01, 0);
    chk("stopheld_done_cleared", {31'd0, done}, 32'd0);
    send(8'hAA, 0);
    send(8'h55, 0);
    trailer(8'hFF, 0);
    chk("stopheld_strt_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("stopheld_run_start", {31'd0, start}, 32'd1);
    chk("stopheld_run_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("stopheld_done_rises", {31'd0, done}, 32'd1);
    stop = 1'b0;
    drain("stopheld");

`ifdef PROG_LOADER_CHKSUM_EN
    exp_wr.push_back('{a: 8'd0, d: 16'h5A0F});
    exp_start.push_back(1'b1);
    send(8'h01, 0);
    send(8'h5A, 0);
    send(8'h0F, 0);
    send(8'h55, 0);
    chk("chk_good_err", {31'd0, err}, 32'd0);
    drain("chk_good");
    do_stop("chk_good");

    exp_wr.push_back('{a: 8'd0, d: 16'h5A0F});
    send(8'h01, 0);
    send(8'h5A, 0);
    send(8'h0F, 0);
    send(8'h54, 0);
    chk("chk_bad_err", {31'd0, err}, 32'd1);
    chk("chk_bad_idle", {29'd0, busy, done, byte_ready}, 32'd1);
    drain("chk_bad");
    chk("chk_bad_err_sticky", {31'd0, err}, 32'd1);

    exp_start.push_back(1'b1);
    send(8'h00, 0);
    chk("chk_err_cleared", {31'd0, err}, 32'd0);
    drain("chk_clear");
    do_stop("chk_clear");
`endif

    // Reset mid-load: header 03, one full word, then a lone high byte
    exp_wr.push_back('{a: 8'd0, d: 16'h1122});
    send(8'h03, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    chk("midload_wr_q_empty", exp_wr.size(), 0);
    rst = 1'b0;
    #1;
    chk("abort_addr", {24'd0, im_w_addr}, 32'd0);
    chk("abort_data", {16'd0, im_w_data}, 32'd0);
    chk("abort_outs", {27'd0, im_wr, start, busy, done, err}, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_held", {27'd0, im_wr, start, busy, done, err}, 32'd0);
    rst = 1'b1;
    chk("abort_ready", {31'd0, byte_ready}, 32'd1);
    exp_wr.push_back('{a: 8'd0, d: 16'h0007});
    exp_start.push_back(1'b1);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h07, 0);
    trailer(8'h07, 0);
    drain("after_abort");
    do_stop("after_abort");

`ifndef PROG_LOADER_CHKSUM_EN
    chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
